rf_seq_ctrl: RTL and testbench
==============================

Name: rf_seq_ctrl

Overview:
- Instruction sequencer for the 8-word x 4-bit, 2-read/1-write register file.
- Accepts one register-to-register instruction per valid/ready handshake.
- Drives both read addresses, computes a 4-bit ALU result with carry/zero flags, and writes the result back through the single write port.
- The register file stays an external instance. This block owns all of its address, data and write-enable pins.

Parameters:
- DW, 4, data width; must match the register file word width.
- AW, 3, register address width (2**AW registers).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- instr_valid  input  1  instruction offered
- instr_ready  output  1  block can accept an instruction this cycle
- instr_op  input  3  opcode (see Behaviour)
- instr_rd  input  AW  destination register
- instr_rs  input  AW  source A register
- instr_ru  input  AW  source B register
- instr_imm  input  DW  immediate for LDI
- rs_addr  output  AW  register file read port A address
- ru_addr  output  AW  register file read port B address
- rs_data  input  DW  register file read port A data (combinational read)
- ru_data  input  DW  register file read port B data (combinational read)
- w_addr  output  AW  register file write address
- w_data  output  DW  register file write data
- w_wr  output  1  register file write enable
- done  output  1  one-cycle pulse, instruction retired
- result  output  DW  last ALU result, held
- flag_c  output  1  carry/borrow of last non-NOP
- flag_z  output  1  zero flag of last non-NOP
- busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Opcodes:
  - 0 NOP
  - 1 LDI: rd<=imm
  - 2 MOV: rd<=rs
  - 3 ADD: rd<=rs+ru
  - 4 SUB: rd<=rs-ru
  - 5 AND
  - 6 OR
  - 7 XOR
- Arithmetic is modulo 2**DW.
- flag_c:
  - ADD: carry out of bit DW-1.
  - SUB: borrow, i.e. 1 when rs<ru unsigned.
  - All other non-NOP ops: 0.
- flag_z: 1 when the result is 0.
- States are CLEAR, IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - valid&&ready latches op/rd/rs/ru/imm and moves to EXEC.
- EXEC:
  - rs_addr/ru_addr driven from the latched rs/ru.
  - ALU evaluates on rs_data/ru_data.
  - The rising edge registers result/flags (skipped for NOP) and moves to WB.
- WB:
  - w_wr=1 (0 for NOP), w_addr=latched rd, w_data=result, done=1, instr_ready=1.
  - A handshake in WB moves to EXEC; otherwise the next state is IDLE.
- Latency: instruction accepted at edge N, write committed at edge N+2. Back-to-back throughput is one instruction per 2 cycles.
- Read-after-write: an instruction accepted in WB reads in EXEC after the WB write edge, so the combinational read sees the new value. No bypass is needed.
- rs_addr/ru_addr hold the latched values outside EXEC.
- Outputs are combinational from state and registers. w_wr and done must never be high outside WB/CLEAR.
- Reset values:
  - state = CLEAR (IDLE without the feature)
  - result = 0, flag_c = 0, flag_z = 0
  - latched fields = 0
  - done = 0, w_wr = 0
- Reset asserted mid-instruction abandons it: no write, no done.
- instr_valid while instr_ready=0 is ignored. The requester must hold the instruction until accepted.
- Opcode input values outside 0..7 are impossible by width.

Optional Feature:
- RF_SEQ_CTRL_CLEAR_EN defined:
  - After reset, state CLEAR sweeps a counter 0..2**AW-1 with w_wr=1, w_addr=count, w_data=0. That is one write per cycle, 8 cycles at default.
  - instr_ready=0 and busy=1 throughout the sweep; done stays 0.
  - After the last address the block enters IDLE.
  - Reset during the sweep restarts it at 0.
- RF_SEQ_CTRL_CLEAR_EN undefined:
  - No CLEAR state; the block is in IDLE immediately after reset.
  - Register contents are undefined until written.

Decomposition:
- Package rf_seq_pkg holds:
  - op_e enum (NOP..XOR, 3 bits)
  - state_e enum (CLEAR, IDLE, EXEC, WB)
  - DW/AW default constants
- Sub-module rf_seq_alu: purely combinational; inputs op, a, b, imm; outputs y, c, z.
- The controller FSM, instruction latch and clear counter stay in rf_seq_ctrl.

Test Plan:
- Reset release with CLEAR_EN -> 8 cycles of w_wr=1, w_addr 0..7, w_data=0, instr_ready=0. Then IDLE with instr_ready=1.
- LDI r1,9 then LDI r2,7, back-to-back with valid held -> accepts 2 cycles apart. Writes r1=9 then r2=7, done pulses 2 cycles apart.
- ADD r3,r1,r2 (9+7) -> w_data=0, flag_c=1, flag_z=1. SUB r4,r2,r1 (7-9) -> w_data=14, flag_c=1, flag_z=0.
- NOP after ADD -> done=1, w_wr=0, flags and result unchanged.
- Read-after-write: ADD r5,r1,r1 immediately followed by XOR r6,r5,r1 -> r5=2, r6=2^9=11.
- rst_n low during EXEC of ADD r7,... -> no w_wr, no done. result and flags return to 0, and the CLEAR sweep restarts at address 0.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared types and default widths for the register-file instruction sequencer.
package rf_seq_pkg;

    localparam int DW_DEF = 4;
    localparam int AW_DEF = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_MOV = 3'd2,
        OP_ADD = 3'd3,
        OP_SUB = 3'd4,
        OP_AND = 3'd5,
        OP_OR  = 3'd6,
        OP_XOR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer: result plus carry/borrow and zero flags.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] y,
    output logic          c,
    output logic          z
);

    logic [DW:0] sum;
    logic [DW:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow (a < b unsigned).
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = '0;
        c = 1'b0;
        case (op_e'(op))
            OP_NOP: y = '0;
            OP_LDI: y = imm;
            OP_MOV: y = a;
            OP_ADD: {c, y} = sum;
            OP_SUB: begin
                y = diff[DW-1:0];
                c = diff[DW];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
        endcase
    end

    assign z = (y == '0);

endmodule

// File: rtl/rf_seq_ctrl.sv
// Instruction sequencer driving an external 2R/1W register file.
// Optional macro RF_SEQ_CTRL_CLEAR_EN adds a post-reset sweep that zeroes every register.
//
// state | meaning
// CLEAR | post-reset sweep writing zero to each register (feature build only)
// IDLE  | waiting for an instruction, ready high
// EXEC  | read ports driven from latched sources, ALU result registered
// WB    | result written back, done pulsed, next instruction may be accepted
module rf_seq_ctrl
    import rf_seq_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [AW-1:0] instr_rd,
    input  logic [AW-1:0] instr_rs,
    input  logic [AW-1:0] instr_ru,
    input  logic [DW-1:0] instr_imm,
    output logic [AW-1:0] rs_addr,
    output logic [AW-1:0] ru_addr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] ru_data,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_data,
    output logic          w_wr,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_c,
    output logic          flag_z,
    output logic          busy
);

`ifdef RF_SEQ_CTRL_CLEAR_EN
    localparam state_e RESET_ST = ST_CLEAR;
`else
    localparam state_e RESET_ST = ST_IDLE;
`endif

    state_e        state_q;
    state_e        state_d;
    op_e           op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] ru_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] result_q;
    logic          c_q;
    logic          z_q;
    logic          load;
    logic          upd;
    logic [DW-1:0] alu_y;
    logic          alu_c;
    logic          alu_z;

    rf_seq_alu #(.DW(DW)) u_alu (
        .op  (op_q),
        .a   (rs_data),
        .b   (ru_data),
        .imm (imm_q),
        .y   (alu_y),
        .c   (alu_c),
        .z   (alu_z)
    );

`ifdef RF_SEQ_CTRL_CLEAR_EN
    logic [AW-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt <= clr_cnt + AW'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RESET_ST;
            op_q     <= OP_NOP;
            rd_q     <= '0;
            rs_q     <= '0;
            ru_q     <= '0;
            imm_q    <= '0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                op_q  <= op_e'(instr_op);
                rd_q  <= instr_rd;
                rs_q  <= instr_rs;
                ru_q  <= instr_ru;
                imm_q <= instr_imm;
            end
            if (upd) begin
                result_q <= alu_y;
                c_q      <= alu_c;
                z_q      <= alu_z;
            end
        end
    end

    // Writes and done are gated by rst_n so a reset edge never commits a write.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        w_wr        = 1'b0;
        w_addr      = rd_q;
        w_data      = result_q;
        done        = 1'b0;
        load        = 1'b0;
        upd         = 1'b0;
        case (state_q)
            ST_CLEAR: begin
`ifdef RF_SEQ_CTRL_CLEAR_EN
                w_wr   = rst_n;
                w_addr = clr_cnt;
                w_data = '0;
                if (clr_cnt == {AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                upd     = (op_q != OP_NOP);
                state_d = ST_WB;
            end
            ST_WB: begin
                instr_ready = 1'b1;
                done        = rst_n;
                w_wr        = rst_n && (op_q != OP_NOP);
                if (instr_valid) begin
                    load    = 1'b1;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign rs_addr = rs_q;
    assign ru_addr = ru_q;
    assign result  = result_q;
    assign flag_c  = c_q;
    assign flag_z  = z_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed self-checking bench for rf_seq_ctrl with a behavioural register file.
module tb_rf_seq_ctrl;
    import rf_seq_pkg::*;

    localparam int DW = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    instr_op = 3'd0;
    logic [AW-1:0] instr_rd = '0;
    logic [AW-1:0] instr_rs = '0;
    logic [AW-1:0] instr_ru = '0;
    logic [DW-1:0] instr_imm = '0;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] ru_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] ru_data;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          w_wr;
    logic          done;
    logic [DW-1:0] result;
    logic          flag_c;
    logic          flag_z;
    logic          busy;

    logic [DW-1:0] rf [8];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rs_data = rf[rs_addr];
    assign ru_data = rf[ru_addr];

    always @(posedge clk) begin
        if (w_wr) rf[w_addr] <= w_data;
    end

    rf_seq_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_ru    (instr_ru),
        .instr_imm   (instr_imm),
        .rs_addr     (rs_addr),
        .ru_addr     (ru_addr),
        .rs_data     (rs_data),
        .ru_data     (ru_data),
        .w_addr      (w_addr),
        .w_data      (w_data),
        .w_wr        (w_wr),
        .done        (done),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .busy        (busy)
    );

    task automatic drive(input op_e op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] ru, input logic [3:0] imm);
        instr_op  = op;
        instr_rd  = rd;
        instr_rs  = rs;
        instr_ru  = ru;
        instr_imm = imm;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where WB is visible.
    task automatic exec_one(input op_e op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [2:0] ru, input logic [3:0] imm);
        drive(op, rd, rs, ru, imm);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_sweep(input string tag);
        logic [2:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            checks++;
            if ({w_wr, w_addr, w_data, instr_ready, busy, done} !== {1'b1, a, 4'd0, 1'b0, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL %s step %0d got wr=%b addr=%0d data=%0d rdy=%b busy=%b done=%b exp wr=1 addr=%0d data=0 rdy=0 busy=1 done=0",
                         tag, i, w_wr, w_addr, w_data, instr_ready, busy, done, a);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({result, flag_c, flag_z, done, w_wr} !== 8'd0) begin
            failures++;
            $display("FAIL reset_vals got res=%0d c=%b z=%b done=%b wr=%b exp all 0", result, flag_c, flag_z, done, w_wr);
        end
        rst_n = 1'b1;
        #1;
`ifdef RF_SEQ_CTRL_CLEAR_EN
        check_sweep("clear_sweep");
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rf[i] !== 4'd0) begin
                failures++;
                $display("FAIL clear_rf r%0d got=%0d exp=0", i, rf[i]);
            end
        end
`endif
        checks++;
        if ({instr_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b exp rdy=1 busy=0", instr_ready, busy);
        end
    endtask

    task automatic test_ldi_back_to_back();
        @(negedge clk);
        drive(OP_LDI, 3'd1, 3'd0, 3'd0, 4'd9);
        instr_valid = 1'b1;
        @(negedge clk);
        drive(OP_LDI, 3'd2, 3'd0, 3'd0, 4'd7);
        checks++;
        if ({instr_ready, busy, w_wr, done} !== 4'b0100) begin
            failures++;
            $display("FAIL ldi1_exec got rdy=%b busy=%b wr=%b done=%b exp 0 1 0 0", instr_ready, busy, w_wr, done);
        end
        @(negedge clk);
        checks++;
        if ({w_wr, done, instr_ready, w_addr, w_data} !== {3'b111, 3'd1, 4'd9}) begin
            failures++;
            $display("FAIL ldi1_wb got wr=%b done=%b rdy=%b addr=%0d data=%0d exp 1 1 1 addr=1 data=9",
                     w_wr, done, instr_ready, w_addr, w_data);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if ({done, instr_ready, busy, rf[1]} !== {3'b001, 4'd9}) begin
            failures++;
            $display("FAIL ldi2_exec got done=%b rdy=%b busy=%b r1=%0d exp done=0 rdy=0 busy=1 r1=9",
                     done, instr_ready, busy, rf[1]);
        end
        @(negedge clk);
        checks++;
        if ({w_wr, done, w_addr, w_data} !== {2'b11, 3'd2, 4'd7}) begin
            failures++;
            $display("FAIL ldi2_wb got wr=%b done=%b addr=%0d data=%0d exp 1 1 addr=2 data=7", w_wr, done, w_addr, w_data);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, rf[2]} !== {2'b00, 4'd7}) begin
            failures++;
            $display("FAIL ldi2_commit got busy=%b done=%b r2=%0d exp busy=0 done=0 r2=7", busy, done, rf[2]);
        end
    endtask

    task automatic test_add_sub();
        exec_one(OP_ADD, 3'd3, 3'd1, 3'd2, 4'd0);
        checks++;
        if ({w_wr, w_addr, w_data, flag_c, flag_z, result} !== {1'b1, 3'd3, 4'd0, 1'b1, 1'b1, 4'd0}) begin
            failures++;
            $display("FAIL add_9_7 got wr=%b addr=%0d data=%0d c=%b z=%b res=%0d exp 1 addr=3 data=0 c=1 z=1 res=0",
                     w_wr, w_addr, w_data, flag_c, flag_z, result);
        end
        @(negedge clk);
        exec_one(OP_SUB, 3'd4, 3'd2, 3'd1, 4'd0);
        checks++;
        if ({w_wr, w_addr, w_data, flag_c, flag_z} !== {1'b1, 3'd4, 4'd14, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_7_9 got wr=%b addr=%0d data=%0d c=%b z=%b exp 1 addr=4 data=14 c=1 z=0",
                     w_wr, w_addr, w_data, flag_c, flag_z);
        end
        @(negedge clk);
        checks++;
        if ({rf[3], rf[4]} !== {4'd0, 4'd14}) begin
            failures++;
            $display("FAIL add_sub_commit got r3=%0d r4=%0d exp r3=0 r4=14", rf[3], rf[4]);
        end
    endtask

    task automatic test_nop();
        exec_one(OP_ADD, 3'd3, 3'd1, 3'd1, 4'd0);
        @(negedge clk);
        exec_one(OP_NOP, 3'd3, 3'd2, 3'd2, 4'd5);
        checks++;
        if ({done, w_wr, result, flag_c, flag_z} !== {2'b10, 4'd2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL nop_wb got done=%b wr=%b res=%0d c=%b z=%b exp done=1 wr=0 res=2 c=1 z=0",
                     done, w_wr, result, flag_c, flag_z);
        end
        @(negedge clk);
        checks++;
        if (rf[3] !== 4'd2) begin
            failures++;
            $display("FAIL nop_keeps_r3 got=%0d exp=2", rf[3]);
        end
    endtask

    task automatic test_read_after_write();
        drive(OP_ADD, 3'd5, 3'd1, 3'd1, 4'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        drive(OP_XOR, 3'd6, 3'd5, 3'd1, 4'd0);
        @(negedge clk);
        checks++;
        if ({w_wr, w_addr, w_data, instr_ready} !== {1'b1, 3'd5, 4'd2, 1'b1}) begin
            failures++;
            $display("FAIL raw_add_wb got wr=%b addr=%0d data=%0d rdy=%b exp 1 addr=5 data=2 rdy=1",
                     w_wr, w_addr, w_data, instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        checks++;
        if ({rs_addr, ru_addr, rs_data} !== {3'd5, 3'd1, 4'd2}) begin
            failures++;
            $display("FAIL raw_xor_exec got rs=%0d ru=%0d rs_data=%0d exp rs=5 ru=1 rs_data=2", rs_addr, ru_addr, rs_data);
        end
        @(negedge clk);
        checks++;
        if ({w_wr, w_addr, w_data, flag_c, flag_z} !== {1'b1, 3'd6, 4'd11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL raw_xor_wb got wr=%b addr=%0d data=%0d c=%b z=%b exp 1 addr=6 data=11 c=0 z=0",
                     w_wr, w_addr, w_data, flag_c, flag_z);
        end
        @(negedge clk);
    endtask

    task automatic test_logic_ops();
        op_e        t_op [6];
        logic [2:0] t_rs [6];
        logic [2:0] t_ru [6];
        logic [3:0] t_imm [6];
        logic [3:0] t_y [6];
        logic       t_c [6];
        logic       t_z [6];
        // r1=9, r2=7
        t_op  = '{OP_AND, OP_OR, OP_MOV, OP_SUB, OP_SUB, OP_LDI};
        t_rs  = '{3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0};
        t_ru  = '{3'd2, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
        t_imm = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        t_y   = '{4'd1, 4'd15, 4'd7, 4'd0, 4'd2, 4'd0};
        t_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t_z   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            exec_one(t_op[i], 3'd0, t_rs[i], t_ru[i], t_imm[i]);
            checks++;
            if ({w_wr, done, w_addr, w_data, flag_c, flag_z} !== {2'b11, 3'd0, t_y[i], t_c[i], t_z[i]}) begin
                failures++;
                $display("FAIL op_table[%0d] got wr=%b done=%b addr=%0d data=%0d c=%b z=%b exp 1 1 addr=0 data=%0d c=%b z=%b",
                         i, w_wr, done, w_addr, w_data, flag_c, flag_z, t_y[i], t_c[i], t_z[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        exec_one(OP_LDI, 3'd7, 3'd0, 3'd0, 4'd5);
        @(negedge clk);
        exec_one(OP_ADD, 3'd3, 3'd1, 3'd1, 4'd0);
        @(negedge clk);
        drive(OP_ADD, 3'd7, 3'd1, 3'd2, 4'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, w_wr, done, flag_c} !== 4'b1001) begin
            failures++;
            $display("FAIL rst_mid_exec got busy=%b wr=%b done=%b c=%b exp busy=1 wr=0 done=0 c=1", busy, w_wr, done, flag_c);
        end
        @(negedge clk);
        checks++;
        if ({result, flag_c, flag_z, done, w_wr, rf[7]} !== {4'd0, 4'b0000, 4'd5}) begin
            failures++;
            $display("FAIL rst_mid_abandon got res=%0d c=%b z=%b done=%b wr=%b r7=%0d exp res=0 c=0 z=0 done=0 wr=0 r7=5",
                     result, flag_c, flag_z, done, w_wr, rf[7]);
        end
        rst_n = 1'b1;
        #1;
`ifdef RF_SEQ_CTRL_CLEAR_EN
        check_sweep("resweep");
        checks++;
        if ({instr_ready, rf[7]} !== {1'b1, 4'd0}) begin
            failures++;
            $display("FAIL resweep_end got rdy=%b r7=%0d exp rdy=1 r7=0", instr_ready, rf[7]);
        end
`else
        checks++;
        if ({instr_ready, busy, rf[7]} !== {2'b10, 4'd5}) begin
            failures++;
            $display("FAIL rst_mid_idle got rdy=%b busy=%b r7=%0d exp rdy=1 busy=0 r7=5", instr_ready, busy, rf[7]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ldi_back_to_back();
        test_add_sub();
        test_nop();
        test_read_after_write();
        test_logic_ops();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
